// File: rtl/pdm_mic_rx_pkg.sv
// Shared defaults and the CIC width helper for the PDM microphone receive path.
package pdm_pkg;

  localparam int unsigned CLK_HALF_DEF = 20;
  localparam int unsigned DECIM_DEF    = 64;
  localparam int unsigned OUT_W_DEF    = 11;
  localparam int unsigned CIC_ORDER    = 3;

  // Register growth of an N-th order CIC is N*log2(R) bits over the 1-bit input.
  function automatic int unsigned cic_width(input int unsigned decim);
    return 1 + CIC_ORDER * $clog2(decim);
  endfunction

endpackage

// File: rtl/pdm_mic_rx_if.sv
// Microphone pins, capture enable and PCM output of the PDM receive path.
interface pdm_mic_rx_if #(
  parameter int unsigned OUT_W = 11
);
  logic             en;
  logic             M_DATA;
  logic             M_CLK;
  logic             M_LRSEL;
  logic [OUT_W-1:0] pcm;
  logic             pcm_valid;

  modport master (
    input  en, M_DATA,
    output M_CLK, M_LRSEL, pcm, pcm_valid
  );

  modport slave (
    output en, M_DATA,
    input  M_CLK, M_LRSEL, pcm, pcm_valid
  );
endinterface

// File: rtl/pdm_mic_rx_cic.sv
// 3rd-order CIC decimator: integrators at the bit rate, combs at the sample rate,
// result scaled to offset-binary PCM with saturation at full scale.
module cic_decim
  import pdm_pkg::*;
#(
  parameter int unsigned DECIM = DECIM_DEF,
  parameter int unsigned CIC_W = cic_width(DECIM),
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             bit_stb,
  input  logic             clear,
  output logic [OUT_W-1:0] pcm,
  output logic             pcm_valid
);

  localparam int unsigned CNT_W = $clog2(DECIM);
  localparam int unsigned SHIFT = CIC_W - OUT_W - 1;

  logic [CIC_W-1:0]       i1, i2, i3;
  logic [CIC_W-1:0]       i1_n, i2_n, i3_n;
  logic [CIC_W-1:0]       d1, d2, d3;
  logic [CIC_W-1:0]       c1, c2, c3;
  logic [CIC_W-SHIFT-1:0] v;
  logic [OUT_W-1:0]       sat;
  logic [CNT_W-1:0]       cnt;
  logic                   dec_stb;

  always_comb begin
    i1_n = i1 + CIC_W'(x);
    i2_n = i2 + i1_n;
    i3_n = i3 + i2_n;
    c1   = i3 - d1;
    c2   = c1 - d2;
    c3   = c2 - d3;
    v    = c3[CIC_W-1:SHIFT];
    // Only the exact full-scale input reaches the bit above the output range.
    sat  = (|(v >> OUT_W)) ? '1 : v[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      cnt       <= '0;
      dec_stb   <= 1'b0;
      pcm       <= '0;
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= 1'b0;
      if (clear) begin
        i1      <= '0;
        i2      <= '0;
        i3      <= '0;
        d1      <= '0;
        d2      <= '0;
        d3      <= '0;
        cnt     <= '0;
        dec_stb <= 1'b0;
      end else begin
        dec_stb <= bit_stb && (cnt == CNT_W'(DECIM - 1));
        if (bit_stb) begin
          i1  <= i1_n;
          i2  <= i2_n;
          i3  <= i3_n;
          cnt <= cnt + CNT_W'(1);
        end
        if (dec_stb) begin
          d1        <= i3;
          d2        <= c1;
          d3        <= c2;
          pcm       <= sat;
          pcm_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: generates M_CLK, synchronizes M_DATA, samples it on
// each M_CLK falling edge and decimates to 11-bit offset-binary PCM.
module pdm_mic_rx
  import pdm_pkg::*;
#(
  parameter int unsigned CLK_HALF = CLK_HALF_DEF,
  parameter int unsigned DECIM    = DECIM_DEF,
  parameter int unsigned CIC_W    = cic_width(DECIM),
  parameter int unsigned OUT_W    = OUT_W_DEF
) (
  input  logic         CLK100MHZ,
  input  logic         RST,
  pdm_mic_rx_if.master mic
);

  localparam int unsigned DIV_W = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;

  logic [DIV_W-1:0] div;
  logic             mclk;
  logic [1:0]       sync;
  logic             bit_stb;
  logic             x_r;
  logic             stb_r;

  // Fires on the cycle whose closing edge drives M_CLK from 1 to 0.
  assign bit_stb = mic.en && mclk && (div == DIV_W'(CLK_HALF - 1));

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      div   <= '0;
      mclk  <= 1'b0;
      sync  <= '0;
      x_r   <= 1'b0;
      stb_r <= 1'b0;
    end else begin
      sync <= {sync[0], mic.M_DATA};
      if (!mic.en) begin
        div   <= '0;
        mclk  <= 1'b0;
        x_r   <= 1'b0;
        stb_r <= 1'b0;
      end else begin
        stb_r <= bit_stb;
        if (bit_stb) begin
          x_r <= sync[1];
        end
        if (div == DIV_W'(CLK_HALF - 1)) begin
          div  <= '0;
          mclk <= ~mclk;
        end else begin
          div <= div + DIV_W'(1);
        end
      end
    end
  end

  cic_decim #(
    .DECIM (DECIM),
    .CIC_W (CIC_W),
    .OUT_W (OUT_W)
  ) u_cic (
    .clk       (CLK100MHZ),
    .rst       (RST),
    .x         (x_r),
    .bit_stb   (stb_r),
    .clear     (~mic.en),
    .pcm       (mic.pcm),
    .pcm_valid (mic.pcm_valid)
  );

  assign mic.M_CLK   = mclk;
  assign mic.M_LRSEL = 1'b0;

endmodule

// File: tb/tb_pdm_mic_rx.sv
// Bench for pdm_mic_rx: the PCM reference is the direct convolution of the captured
// bit history with the cubed boxcar impulse response, compared on every cycle.
module tb_pdm_mic_rx;

  localparam int CH = 20;
  localparam int D  = 64;
  localparam int OW = 11;
  localparam int SH = 7;
  localparam int NT = 3 * D - 2;
  localparam int MAXV = (1 << OW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pdm_mic_rx_if #(.OUT_W(OW)) bus ();

  pdm_mic_rx #(
    .CLK_HALF (CH),
    .DECIM    (D),
    .OUT_W    (OW)
  ) dut (
    .CLK100MHZ (clk),
    .RST       (rst),
    .mic       (bus)
  );

  int total = 0;
  int bad   = 0;

  int h [NT];
  bit bits [0:16383];

  int ecyc = -1;
  int nb   = 0;
  int due  = -1;
  int mode = 0;
  int cyc  = 0;
  int first_after = -1;
  int rel  = 0;
  bit live = 1'b0;
  logic          exp_mclk  = 1'b0;
  logic          exp_valid = 1'b0;
  logic [OW-1:0] exp_pcm   = '0;
  logic [OW-1:0] pend      = '0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d want %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int pat(input int m, input int k);
    case (m)
      0:       return 1;
      1:       return 0;
      2:       return (k % 2 == 0) ? 1 : 0;
      3:       return (k % 4 != 3) ? 1 : 0;
      default: return int'($urandom_range(0, 1));
    endcase
  endfunction

  // n-th PCM sample (1-based): FIR over the bit history, zero before capture start.
  function automatic int model_pcm(input int n);
    int y;
    int base;
    int v;
    y    = 0;
    base = n * D - 1;
    for (int j = 0; j < NT; j++)
      if (base - j >= 0) y += h[j] * int'(bits[base - j]);
    v = y >>> SH;
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic step(input logic r, input logic e);
    @(posedge clk);
    #1;
    cyc++;
    rst    = r;
    bus.en = e;
    if (r) begin
      ecyc = -1; nb = 0; due = -1;
      exp_pcm = '0; exp_valid = 1'b0; exp_mclk = 1'b0;
    end else if (!e) begin
      ecyc = -1; nb = 0; due = -1;
      exp_valid = 1'b0; exp_mclk = 1'b0;
    end else begin
      ecyc++;
      exp_mclk = ((ecyc % (2 * CH)) >= CH);
      if (ecyc % (2 * CH) == CH) begin
        bits[nb]   = pat(mode, nb) != 0;
        bus.M_DATA = bits[nb];
      end
      if (ecyc % (2 * CH) == 2 * CH - 1) begin
        nb++;
        if (nb % D == 0) begin
          pend = OW'(model_pcm(nb / D));
          due  = ecyc + 3;
        end
      end
      exp_valid = (ecyc == due);
      if (exp_valid) exp_pcm = pend;
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      check("m_clk", int'(bus.M_CLK), int'(exp_mclk));
      check("pcm_valid", int'(bus.pcm_valid), int'(exp_valid));
      check("pcm", int'(bus.pcm), int'(exp_pcm));
      check("m_lrsel", int'(bus.M_LRSEL), 0);
      if (bus.pcm_valid && first_after < 0) first_after = cyc;
    end
  end

  task automatic run_strobes(input int n);
    repeat (2562 + 2560 * (n - 1) + 1) step(1'b0, 1'b1);
    @(negedge clk);
    #1;
  endtask

  task automatic pattern_phase(input int m, input int lit, input string nm);
    mode = m;
    step(1'b1, 1'b0);
    run_strobes(4);
    check({nm, "_model"}, int'(exp_pcm), lit);
    check({nm, "_dut"}, int'(bus.pcm), lit);
  endtask

  initial begin
    int hs;
    int guard;
    logic [OW-1:0] held;

    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.M_DATA = 1'b0;

    for (int i = 0; i < NT; i++) h[i] = 0;
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++)
        for (int k = 0; k < D; k++)
          h[i + j + k]++;
    hs = 0;
    for (int i = 0; i < NT; i++) hs += h[i];
    check("h_sum", hs, D * D * D);
    check("h_mid", h[NT / 2], 3 * D * D / 4);

    step(1'b1, 1'b0);
    live = 1'b1;
    repeat (2) step(1'b1, 1'b0);
    check("rst_pcm", int'(bus.pcm), 0);
    check("rst_valid", int'(bus.pcm_valid), 0);
    check("rst_mclk", int'(bus.M_CLK), 0);

    pattern_phase(0, 2047, "ones");

    // Run on to decimation count 30 with M_CLK high, then pulse reset.
    guard = 0;
    while (!(nb % D == 30 && ecyc % (2 * CH) == 25) && guard < 4000) begin
      step(1'b0, 1'b1);
      guard++;
    end
    check("pre_rst_mclk", int'(bus.M_CLK), 1);
    step(1'b1, 1'b1);
    #1;
    check("async_mclk", int'(bus.M_CLK), 0);
    check("async_pcm", int'(bus.pcm), 0);
    check("async_valid", int'(bus.pcm_valid), 0);
    first_after = -1;
    step(1'b0, 1'b1);
    rel = cyc;
    repeat (2562) step(1'b0, 1'b1);
    @(negedge clk);
    #1;
    check("rst_release_latency", first_after - rel, 2562);

    pattern_phase(1, 0, "zeros");
    pattern_phase(2, 1024, "alt");
    pattern_phase(3, 1536, "d34");

    mode = 4;
    step(1'b1, 1'b0);
    run_strobes(3);
    repeat (1000) step(1'b0, 1'b1);
    held = exp_pcm;
    first_after = -1;
    repeat (100) step(1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("en_low_hold", int'(bus.pcm), int'(held));
    check("en_low_no_valid", first_after, -1);
    step(1'b0, 1'b1);
    rel = cyc;
    repeat (2562) step(1'b0, 1'b1);
    @(negedge clk);
    #1;
    check("en_return_latency", first_after - rel, 2562);

    live = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
